// File: rtl/apu_wb_queue_if.sv
// rtl/apu_wb_queue_if.sv - APU result / register-file write-back bus for apu_wb_queue
interface apu_wb_queue_if #(
    parameter int DEPTH         = 4,
    parameter int data_width    = 32,
    parameter int reg_sel_width = 5
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                     in_valid;
    logic                     in_ready;
    logic [reg_sel_width-1:0] in_sel;
    logic [data_width-1:0]    in_data;
    logic                     rf_wr_req;
    logic                     rf_ack;
    logic [reg_sel_width-1:0] rf_wr_sel;
    logic [data_width-1:0]    rf_wr_data;
    logic [reg_sel_width-1:0] pend_sel;
    logic                     pend_hit;
    logic [CW-1:0]            count;
    logic                     empty;

    modport master (
        output in_valid, in_sel, in_data, rf_ack, pend_sel,
        input  in_ready, rf_wr_req, rf_wr_sel, rf_wr_data, pend_hit, count, empty
    );

    modport slave (
        input  in_valid, in_sel, in_data, rf_ack, pend_sel,
        output in_ready, rf_wr_req, rf_wr_sel, rf_wr_data, pend_hit, count, empty
    );
endinterface

// File: rtl/apu_wb_queue.sv
// rtl/apu_wb_queue.sv - in-order APU write-back queue feeding the register-file APU write port
module apu_wb_queue #(
    parameter int DEPTH         = 4,
    parameter int data_width    = 32,
    parameter int reg_sel_width = 5
) (
    input  logic           clk,
    input  logic           rst,
    apu_wb_queue_if.slave  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    logic [reg_sel_width-1:0] mem_sel  [DEPTH];
    logic [data_width-1:0]    mem_data [DEPTH];
    logic [PW-1:0]            head;
    logic [PW-1:0]            tail;
    logic [CW-1:0]            cnt;
    state_t                   state;
    logic                     wr_req;
    logic                     accept;
    logic                     push;
    logic                     pop;
    logic                     hit;
    logic [PW-1:0]            off;

    // Writes to x0 are handshaken but never stored.
    assign accept = bus.in_valid && (cnt < CW'(DEPTH));
    assign push   = accept && (bus.in_sel != '0);
    assign pop    = (state == WAIT) && bus.rf_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_sel[tail]  <= bus.in_sel;
            mem_data[tail] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            wr_req <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cnt != '0) begin
                        state  <= ISSUE;
                        wr_req <= 1'b1;
                    end else begin
                        wr_req <= 1'b0;
                    end
                end
                ISSUE: begin
                    state  <= WAIT;
                    wr_req <= 1'b0;
                end
                WAIT: begin
                    // Entries left after this pop, counting a same-cycle push.
                    if (bus.rf_ack) begin
                        if ((cnt > CW'(1)) || push) begin
                            state  <= ISSUE;
                            wr_req <= 1'b1;
                        end else begin
                            state  <= IDLE;
                            wr_req <= 1'b0;
                        end
                    end else begin
                        wr_req <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    wr_req <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        hit = 1'b0;
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - head;
            if ((CW'(off) < cnt) && (mem_sel[i] == bus.pend_sel)) hit = 1'b1;
        end
    end

    assign bus.in_ready   = (cnt < CW'(DEPTH));
    assign bus.rf_wr_req  = wr_req;
    assign bus.rf_wr_sel  = mem_sel[head];
    assign bus.rf_wr_data = mem_data[head];
    assign bus.pend_hit   = hit && (bus.pend_sel != '0);
    assign bus.count      = cnt;
    assign bus.empty      = (cnt == '0);
endmodule

// File: tb/tb_apu_wb_queue.sv
// tb/tb_apu_wb_queue.sv - randomized bench for apu_wb_queue against a queue-based model
module tb_apu_wb_queue;
    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int SW    = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    apu_wb_queue_if #(.DEPTH(DEPTH), .data_width(DW), .reg_sel_width(SW)) bus ();

    apu_wb_queue #(.DEPTH(DEPTH), .data_width(DW), .reg_sel_width(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [SW-1:0] sel;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          q[$];
    bit            m_req;
    bit            m_wait;
    bit            pend_fixed;
    logic [SW-1:0] pend_val;
    int            n_tests;
    int            n_fail;
    int            n_cyc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, n_cyc, obs, exp);
        end
    endtask

    function automatic bit model_hit(input logic [SW-1:0] s);
        if (s == '0) return 1'b0;
        foreach (q[i]) if (q[i].sel == s) return 1'b1;
        return 1'b0;
    endfunction

    task automatic cycle(input bit v, input logic [SW-1:0] s, input logic [DW-1:0] d,
                         input bit a, input bit r);
        bit   enq;
        ent_t e;
        rst          = r;
        bus.in_valid = v;
        bus.in_sel   = s;
        bus.in_data  = d;
        bus.rf_ack   = a;
        enq = v && (q.size() < DEPTH) && (s != '0);
        @(posedge clk);
        n_cyc++;
        if (r) begin
            q.delete();
            m_req  = 1'b0;
            m_wait = 1'b0;
        end else begin
            // One request pulse per head entry, reissued right after an ack if work remains.
            if (m_req) begin
                m_req  = 1'b0;
                m_wait = 1'b1;
            end else if (m_wait) begin
                if (a) begin
                    q.delete(0);
                    m_wait = 1'b0;
                    m_req  = (q.size() + int'(enq)) > 0;
                end
            end else begin
                m_req = q.size() > 0;
            end
            if (enq) begin
                e.sel  = s;
                e.data = d;
                q.push_back(e);
            end
        end
        if (pend_fixed) bus.pend_sel = pend_val;
        else if (q.size() > 0 && $urandom_range(1, 0) == 1)
            bus.pend_sel = q[$urandom_range(q.size() - 1, 0)].sel;
        else bus.pend_sel = SW'($urandom);
        #1;
        chk("count", bus.count, q.size());
        chk("empty", bus.empty, q.size() == 0);
        chk("in_ready", bus.in_ready, q.size() < DEPTH);
        chk("rf_wr_req", bus.rf_wr_req, m_req);
        if (m_req || m_wait) begin
            chk("rf_wr_sel", bus.rf_wr_sel, q[0].sel);
            chk("rf_wr_data", bus.rf_wr_data, q[0].data);
        end
        chk("pend_hit", bus.pend_hit, model_hit(bus.pend_sel));
    endtask

    task automatic idle_ack(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, m_wait, 1'b0);
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        n_cyc        = 0;
        m_req        = 1'b0;
        m_wait       = 1'b0;
        pend_fixed   = 1'b0;
        pend_val     = '0;
        bus.in_valid = 1'b0;
        bus.in_sel   = '0;
        bus.in_data  = '0;
        bus.rf_ack   = 1'b0;
        bus.pend_sel = '0;

        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        cycle(1'b1, 5'd3, 32'h1111_2222, 1'b1, 1'b1);

        pend_fixed = 1'b1;
        pend_val   = 5'd5;
        cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b0);
        idle_ack(6);

        pend_val = 5'd0;
        cycle(1'b1, 5'd0, 32'h0000_1234, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0);

        pend_fixed = 1'b0;
        for (int i = 0; i < 6; i++)
            cycle(1'b1, SW'($urandom_range(31, 1)), $urandom, 1'b0, 1'b0);
        idle_ack(20);

        cycle(1'b1, 5'd7, 32'hA5A5_0007, 1'b0, 1'b0);
        for (int i = 0; i < 6 && !m_wait; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0);
        cycle(1'b1, 5'd9, 32'h5A5A_0009, 1'b1, 1'b0);
        idle_ack(10);

        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, SW'($urandom_range(31, 1)), $urandom, 1'b0, 1'b0);
            idle_ack(4);
        end

        for (int i = 0; i < 600; i++)
            cycle($urandom_range(1, 0) == 1, SW'($urandom), $urandom,
                  $urandom_range(2, 0) != 0, 1'b0);
        idle_ack(20);

        for (int i = 0; i < 3; i++)
            cycle(1'b1, SW'($urandom_range(31, 1)), $urandom, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0);
        cycle(1'b1, 5'd3, 32'hBAD0_0003, 1'b1, 1'b1);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
